// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: round-robin arbiter and grant sequencer for one shared resource.
// Grants are registered and one-hot. A grant is held until the owner releases it
// by pulsing done or dropping req. Every change of owner passes through one IDLE cycle.
// Optional macro RR_ARB_TIMEOUT_EN builds an 8-bit hold counter.
// With the macro, a grant that reaches MAX_HOLD cycles is revoked and timeout pulses.
module rr_arbiter_ctrl #(
  parameter int N_REQ     = 3,
  parameter int PTR_WIDTH = 2,
  parameter int MAX_HOLD  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     gnt,
  output logic [PTR_WIDTH-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam bit HOLD_CFG_OK = (MAX_HOLD >= 1) && (MAX_HOLD <= 255);

  state_t               state_r;
  logic [PTR_WIDTH-1:0] ptr_r;
  logic [N_REQ-1:0]     pick_oh_s;
  logic [PTR_WIDTH-1:0] pick_idx_s;
  logic                 pick_valid_s;
  logic                 release_s;
  logic [PTR_WIDTH-1:0] ptr_next_s;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_r;
  logic       timeout_r;
  assign timeout = timeout_r & HOLD_CFG_OK;
`else
  // Without the hold timer a grant can never be revoked, so timeout is constant low.
  assign timeout = 1'b0 & HOLD_CFG_OK;
`endif

  // Search ptr, ptr+1, ... with wrap. Scanning from the far end lets the nearest requester win.
  always_comb begin
    logic [PTR_WIDTH:0] sum_s;
    logic [PTR_WIDTH-1:0] idx_s;
    pick_oh_s    = {N_REQ{1'b0}};
    pick_idx_s   = ptr_r;
    pick_valid_s = 1'b0;
    sum_s        = {(PTR_WIDTH+1){1'b0}};
    idx_s        = {PTR_WIDTH{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum_s = {1'b0, ptr_r} + (PTR_WIDTH+1)'(k);
      idx_s = (sum_s >= (PTR_WIDTH+1)'(N_REQ)) ? PTR_WIDTH'(sum_s - (PTR_WIDTH+1)'(N_REQ))
                                                : PTR_WIDTH'(sum_s);
      if (req[idx_s]) begin
        pick_oh_s        = {N_REQ{1'b0}};
        pick_oh_s[idx_s] = 1'b1;
        pick_idx_s       = idx_s;
        pick_valid_s     = 1'b1;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Owner releases on its own done bit or by dropping its request; the other bits are masked by gnt.
  always_comb begin
    release_s  = (|(done & gnt)) | ~(|(req & gnt));
    ptr_next_s = (gnt_id == PTR_WIDTH'(N_REQ - 1)) ? {PTR_WIDTH{1'b0}}
                                                   : gnt_id + PTR_WIDTH'(1);
  end

  // Two-state grant FSM with registered grant outputs, pointer and optional hold timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      gnt     <= {N_REQ{1'b0}};
      gnt_id  <= {PTR_WIDTH{1'b0}};
      busy    <= 1'b0;
      ptr_r   <= {PTR_WIDTH{1'b0}};
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_r <= 8'd0;
      timeout_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
`ifdef RR_ARB_TIMEOUT_EN
          timeout_r <= 1'b0;
`endif
          if (pick_valid_s) begin
            state_r <= GRANT;
            gnt     <= pick_oh_s;
            gnt_id  <= pick_idx_s;
            busy    <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_r <= 8'd0;
`endif
          end else begin
            state_r <= IDLE;
            gnt     <= {N_REQ{1'b0}};
            busy    <= 1'b0;
          end
        end
        GRANT: begin
          if (release_s) begin
            state_r <= IDLE;
            gnt     <= {N_REQ{1'b0}};
            busy    <= 1'b0;
            ptr_r   <= ptr_next_s;
`ifdef RR_ARB_TIMEOUT_EN
            timeout_r <= 1'b0;
          end else if (hold_cnt_r == HOLD_LAST) begin
            // Revocation behaves exactly like a release, plus a one-cycle timeout pulse.
            state_r   <= IDLE;
            gnt       <= {N_REQ{1'b0}};
            busy      <= 1'b0;
            ptr_r     <= ptr_next_s;
            timeout_r <= 1'b1;
          end else begin
            hold_cnt_r <= (hold_cnt_r == 8'hFF) ? 8'hFF : hold_cnt_r + 8'd1;
            timeout_r  <= 1'b0;
`else
          end else begin
            state_r <= GRANT;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          gnt     <= {N_REQ{1'b0}};
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Bench for rr_arbiter_ctrl: directed vectors with literal expectations, plus a
// cycle-by-cycle comparison against a behavioural round-robin model.
module tb_rr_arbiter_ctrl;
  localparam int N    = 3;
  localparam int MAXH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter_ctrl #(.N_REQ(N), .PTR_WIDTH(2), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  logic [N-1:0] req_q, done_q;
  logic         rst_q;
  always @(posedge clk) begin
    req_q  <= req;
    done_q <= done;
    rst_q  <= reset;
  end

  // Behavioural model: owner (-1 when idle), pointer, last owner, timeout pulse.
  int m_owner, m_ptr, m_last;
  bit m_to;
`ifdef RR_ARB_TIMEOUT_EN
  int m_hold;
`endif

  initial begin
    m_owner = -1; m_ptr = 0; m_last = 0; m_to = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    m_hold = 0;
`endif
    forever begin
      @(negedge clk);
      if (reset || rst_q) begin
        m_owner = -1; m_ptr = 0; m_last = 0; m_to = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        m_hold = 0;
`endif
      end else begin
        m_to = 1'b0;
        if (m_owner < 0) begin
          for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && bit_of(req_q, (m_ptr + k) % N)) begin
              m_owner = (m_ptr + k) % N;
              m_last  = m_owner;
`ifdef RR_ARB_TIMEOUT_EN
              m_hold  = 0;
`endif
            end
          end
        end else if (bit_of(done_q, m_owner) || !bit_of(req_q, m_owner)) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (m_hold == MAXH - 1) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_to    = 1'b1;
        end else begin
          m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        end
`endif
      end
      chk("model_gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("model_gnt_id", 32'(gnt_id), 32'(m_last));
      chk("model_busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
      chk("model_timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Abort the run if it ever stops making progress.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req = 3'b000; done = 3'b000;
    cyc(); cyc();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;

    // Full rotation with done pulsed by each owner.
    req = 3'b111;
    cyc(); chk("rot_g0", 32'(gnt), 32'h1);
    done = 3'b001; cyc(); chk("rot_gap0", 32'(gnt), 32'h0);
    done = 3'b000; cyc(); chk("rot_g1", 32'(gnt), 32'h2);
    done = 3'b010; cyc(); chk("rot_gap1", 32'(gnt), 32'h0);
    done = 3'b000; cyc(); chk("rot_g2", 32'(gnt), 32'h4);
    done = 3'b100; cyc(); chk("rot_gap2", 32'(gnt), 32'h0);
    done = 3'b000; cyc(); chk("rot_g3", 32'(gnt), 32'h1);

    // Non-owner done bits are ignored.
    done = 3'b110;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("nonowner_gnt", 32'(gnt), 32'h1);
      chk("nonowner_busy", 32'(busy), 32'h1);
    end
    done = 3'b000;

    // Owner drops its request: release and pointer advances to 1.
    req = 3'b110;
    cyc(); chk("drop_gnt", 32'(gnt), 32'h0); chk("drop_busy", 32'(busy), 32'h0);
    cyc(); chk("drop_next", 32'(gnt), 32'h2); chk("drop_id", 32'(gnt_id), 32'h1);

    // Pointer wrap after owner 2 releases.
    done = 3'b010; cyc(); chk("wrap_rel1", 32'(gnt), 32'h0);
    done = 3'b000; req = 3'b100; cyc(); chk("wrap_g2", 32'(gnt), 32'h4);
    req = 3'b101; done = 3'b100; cyc(); chk("wrap_rel2", 32'(gnt), 32'h0);
    done = 3'b000; cyc(); chk("wrap_g0", 32'(gnt), 32'h1); chk("wrap_id", 32'(gnt_id), 32'h0);

    // Single persistent requester alternates GRANT and IDLE.
    req = 3'b001; done = 3'b001;
    cyc(); chk("single_0", 32'(gnt), 32'h0);
    cyc(); chk("single_1", 32'(gnt), 32'h1);
    cyc(); chk("single_2", 32'(gnt), 32'h0);
    cyc(); chk("single_3", 32'(gnt), 32'h1);

    // Reset while owner 1 holds the grant.
    req = 3'b011; done = 3'b001; cyc(); chk("pre_rst_rel", 32'(gnt), 32'h0);
    done = 3'b000; cyc(); chk("pre_rst_g1", 32'(gnt), 32'h2);
    #2; reset = 1'b1; #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_id", 32'(gnt_id), 32'h0);
    cyc(); cyc();
    reset = 1'b0; req = 3'b111;
    cyc(); chk("post_rst_g", 32'(gnt), 32'h1);

    // Long hold by owner 1.
    done = 3'b001; req = 3'b010; cyc(); chk("hold_rel", 32'(gnt), 32'h0);
    done = 3'b000; cyc(); chk("hold_g", 32'(gnt), 32'h2);
`ifdef RR_ARB_TIMEOUT_EN
    req = 3'b011;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("to_held", 32'(gnt), 32'h2);
    end
    cyc(); chk("to_drop", 32'(gnt), 32'h0); chk("to_pulse", 32'(timeout), 32'h1);
    cyc(); chk("to_next", 32'(gnt), 32'h1); chk("to_clear", 32'(timeout), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("nohold_gnt", 32'(gnt), 32'h2);
      chk("nohold_timeout", 32'(timeout), 32'h0);
    end
`endif

    req = 3'b000;
    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_ctrl.md
# rr_arbiter_ctrl

- Round-robin arbiter and grant sequencer that shares one modulo-counter resource among `N_REQ` requesters.
- Priority rotates through a mod-`N_REQ` pointer, the same wrap behaviour as the team's mod-N counters.
- Grants are registered and one-hot, and a grant is held until the owner signals `done`.
- An optional hold-timeout revokes a stuck grant.

## Interface
- `N_REQ`, default 3: number of requesters; must be ≥2.
- `PTR_WIDTH`, default 2: width of `gnt_id` and of the priority pointer; must satisfy 2^`PTR_WIDTH` ≥ `N_REQ`.
- `MAX_HOLD`, default 8: maximum grant length in cycles when the timeout is compiled in; range 1..255.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input `N_REQ`: request per requester; level-sensitive; held high until granted.
- `done` input `N_REQ`: release strobe per requester; only the bit of the current owner is honoured.
- `gnt` output `N_REQ`: registered one-hot grant, or all zero.
- `gnt_id` output `PTR_WIDTH`: index of the current owner; holds the last owner while idle.
- `busy` output 1: high while in GRANT.
- `timeout` output 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- The FSM has two states, IDLE and GRANT.
- Pointer `ptr` ranges 0..`N_REQ`-1. It marks the highest-priority requester.
- **Search order:** `ptr`, `ptr`+1, …, wrapping `N_REQ`-1 → 0.
- **IDLE:**
  - If any `req` bit is high, pick the first requester in search order, call it i.
  - Next state GRANT; `gnt` = 1<<i; `gnt_id` = i; `busy` = 1.
  - If no `req` bit is high, stay in IDLE; `gnt` = 0 and `ptr` is unchanged.
- **GRANT (owner i):** release when `done[i]`=1 or `req[i]`=0. On release:
  - next state IDLE;
  - `gnt` = 0, `busy` = 0;
  - `ptr` = (i+1) mod `N_REQ`, with an explicit wrap from `N_REQ`-1 to 0.
- `done` bits of non-owners are ignored in every state. `done` seen in IDLE is ignored.
- Changes in other requesters' `req` bits during GRANT do not affect the current grant.
- `gnt` is never multi-hot and never changes owner without passing through IDLE.
- **Reset values** (asynchronous; reset mid-grant drops `gnt` immediately):
  - state IDLE;
  - `gnt` = 0, `gnt_id` = 0, `busy` = 0, `timeout` = 0;
  - `ptr` = 0, hold counter = 0.

## Timing
- **Grant latency:** `req` sampled high at edge t in IDLE gives `gnt` high from edge t onward (registered). With `req` asserted in cycle t-1, the grant is visible in cycle t.
- **Release latency:** `done[i]` sampled at edge t gives `gnt` low from edge t. The following cycle is IDLE.
- The earliest next grant is the next edge. Back-to-back owners therefore see at least one cycle with `gnt` = 0.
- **Simultaneous `done[i]` and other requests:** release wins. The new owner is chosen in the IDLE cycle using the updated `ptr`.
- **Single persistent requester i:** re-granted every second cycle, alternating GRANT and IDLE.
- **Hold counter:** 8 bits. Cleared on entry to GRANT; increments each cycle in GRANT; saturates at 255.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- **Defined:**
  - When the hold counter reaches `MAX_HOLD`-1 in GRANT without a release, the next edge applies the same transition as a release: go to IDLE and advance `ptr` past i.
  - `timeout` pulses high for exactly that one cycle.
  - A release on the same edge takes precedence, and `timeout` stays 0.
- **Undefined:**
  - The hold counter is not instantiated and `timeout` is tied to 0.
  - A grant lasts until `done[i]` or until `req[i]` drops.

## Test plan
- **Reset mid-grant:** assert `reset` while `gnt`=3'b010. `gnt`, `busy` and `gnt_id` go to 0 without waiting for `clk`. `ptr`=0 after release, so with `req`=3'b111 the first grant is 3'b001.
- **Full rotation:** `req`=3'b111 held, `done` pulsed for the owner each GRANT cycle. Grant order is 001, 010, 100, 001, with one zero-`gnt` cycle between each.
- **Pointer wrap:** owner 2 releases, then `req`=3'b101. Next grant is 3'b001 (`ptr` wrapped to 0), and `gnt_id`=0.
- **Non-owner `done` ignored:** owner 0 with `done`=3'b110 for 3 cycles. `gnt` stays 3'b001 and `busy` stays 1.
- **Timeout, with `RR_ARB_TIMEOUT_EN`:**
  - `MAX_HOLD`=4, owner 1, no `done`.
  - `gnt` stays high for 4 cycles, then drops with a 1-cycle `timeout` pulse.
  - With `req`=3'b011, the next grant is 3'b001.
  - Without the macro: `gnt` stays 3'b010 for 20+ cycles and `timeout` stays 0.
- **Request drop:** the owner drops `req` with no `done`. `gnt` goes to 0 the next edge and `ptr` advances.
